// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// alu_share_arbiter: round-robin share of one integer ALU between two
// requesters, with a single registered, id-tagged response slot.
// Optional build macro ALU_SHARE_ARBITER_STATS_EN adds grant/conflict counters.
// Revision: 1.0
// ============================================================================
module alu_share_arbiter #(
  parameter int DATA_W     = 32,
  parameter int RESET_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal
`ifdef ALU_SHARE_ARBITER_STATS_EN
  ,
  output logic [15:0]       stat_grant0,
  output logic [15:0]       stat_grant1,
  output logic [15:0]       stat_conflict
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant;
  logic                slot_free;
  logic                winner;
  logic                accept;
  logic [2:0]          sel_op;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_illegal;

  assign rsp_valid = (state_q == FULL);
  assign slot_free = !rsp_valid || rsp_ready;

  // On a tie the requester not granted last wins; otherwise the lone valid one.
  always_comb begin
    winner = req1_valid;
    if (req0_valid && req1_valid) winner = ~last_grant;
  end

  // Reset gates the grants so nothing is accepted in the reset cycle.
  assign req0_ready = !reset && slot_free && req0_valid && !winner;
  assign req1_ready = !reset && slot_free && req1_valid &&  winner;
  assign accept     = req0_ready || req1_ready;

  assign sel_op = winner ? req1_op : req0_op;
  assign sel_a  = winner ? req1_a  : req0_a;
  assign sel_b  = winner ? req1_b  : req0_b;

  always_comb begin
    alu_result  = '0;
    alu_illegal = 1'b0;
    case (sel_op)
      3'b000:  alu_result = sel_a + sel_b;
      3'b001:  alu_result = sel_a - sel_b;
      3'b010:  alu_result = sel_a & sel_b;
      3'b011:  alu_result = sel_a | sel_b;
      3'b101:  alu_result = {{(DATA_W-1){1'b0}}, (sel_a < sel_b)};
      default: alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)         state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
      last_grant  <= (RESET_PRIO == 0);
    end else if (accept) begin
      rsp_id      <= winner;
      rsp_result  <= alu_result;
      rsp_zero    <= (alu_result == '0);
      rsp_illegal <= alu_illegal;
      last_grant  <= winner;
    end
  end

`ifdef ALU_SHARE_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (req0_ready && stat_grant0 != 16'hFFFF) stat_grant0 <= stat_grant0 + 16'd1;
      if (req1_ready && stat_grant1 != 16'hFFFF) stat_grant1 <= stat_grant1 + 16'd1;
      if (req0_valid && req1_valid && slot_free && stat_conflict != 16'hFFFF)
        stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// Randomized and directed bench for alu_share_arbiter against a transaction-level model.
module tb_alu_share_arbiter;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [2:0]        req0_op, req1_op;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal;
  logic [DATA_W-1:0] rsp_result;
`ifdef ALU_SHARE_ARBITER_STATS_EN
  logic [15:0] stat_grant0, stat_grant1, stat_conflict;
  int m_g0, m_g1, m_cf;
`endif

  alu_share_arbiter #(.DATA_W(DATA_W), .RESET_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
`ifdef ALU_SHARE_ARBITER_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model of the response slot
  logic              m_valid, m_id, m_zero, m_ill, m_last;
  logic [DATA_W-1:0] m_res;
  logic              exp0, exp1, got0, got1;

  function automatic logic [DATA_W:0] ref_alu(input logic [2:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    case (op)
      3'd0:    return {1'b0, a + b};
      3'd1:    return {1'b0, a - b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd5:    return {1'b0, DATA_W'((a < b) ? 1 : 0)};
      default: return {1'b1, {DATA_W{1'b0}}};
    endcase
  endfunction

  // One clock: inputs are already applied at the preceding negedge.
  task automatic step();
    logic free, w;
    logic [DATA_W:0] r;
    #1;
    check("rsp_valid", rsp_valid, m_valid);
    if (m_valid) begin
      check("rsp_id", rsp_id, m_id);
      check("rsp_result", rsp_result, m_res);
      check("rsp_zero", rsp_zero, m_zero);
      check("rsp_illegal", rsp_illegal, m_ill);
    end
    free = !m_valid || rsp_ready;
    w    = (req0_valid && req1_valid) ? !m_last : req1_valid;
    exp0 = !reset && free && req0_valid && !w;
    exp1 = !reset && free && req1_valid && w;
    got0 = req0_ready;
    got1 = req1_ready;
    check("req0_ready", got0, exp0);
    check("req1_ready", got1, exp1);
`ifdef ALU_SHARE_ARBITER_STATS_EN
    if (reset) begin m_g0 = 0; m_g1 = 0; m_cf = 0; end
    else begin
      m_g0 += int'(exp0); m_g1 += int'(exp1);
      m_cf += int'(req0_valid && req1_valid && free);
    end
`endif
    if (reset) begin
      m_valid = 0; m_id = 0; m_res = '0; m_zero = 0; m_ill = 0; m_last = 1'b1;
    end else if (exp0 || exp1) begin
      r = exp1 ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
      m_valid = 1; m_id = exp1; m_ill = r[DATA_W]; m_res = r[DATA_W-1:0];
      m_zero = (m_res == '0); m_last = exp1;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic set0(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask
  task automatic set1(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic do_reset();
    reset = 1; step(); step(); reset = 0;
  endtask

  logic       p0, p1;
  logic [4:0] order;

  initial begin
    m_valid = 0; m_id = 0; m_res = '0; m_zero = 0; m_ill = 0; m_last = 1;
    reset = 1; rsp_ready = 1;
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    @(negedge clk);
    do_reset();
    check("reset_valid", rsp_valid, 0);

    // single add
    set0(1, 3'b000, 5, 7); step(); set0(0, 0, 0, 0);
    check("add_ready", got0, 1);
    check("add_valid", rsp_valid, 1);
    check("add_result", rsp_result, 12);
    check("add_id", rsp_id, 0);

    // sub to zero, then wrap
    set1(1, 3'b001, 9, 9); step(); set1(0, 0, 0, 0);
    check("sub_result", rsp_result, 0);
    check("sub_zero", rsp_zero, 1);
    check("sub_id", rsp_id, 1);
    set0(1, 3'b000, 32'hFFFF_FFFF, 1); step(); set0(0, 0, 0, 0);
    check("wrap_result", rsp_result, 0);
    check("wrap_zero", rsp_zero, 1);

    // contention after reset: grants alternate starting with requester 0
    do_reset();
    order = '0;
    for (int i = 0; i < 4; i++) begin
      set0(1, 3'b000, 32'(i), 100); set1(1, 3'b011, 32'(i), 32'h10);
      step();
      order[i] = got1;
      check("rr_id", rsp_id, 32'(i % 2));
    end
    check("rr_order", order[3:0], 4'b1010);

    // backpressure
    rsp_ready = 0;
    set0(1, 3'b010, 32'hF0F0, 32'hFF00); set1(1, 3'b000, 1, 2);
    for (int i = 0; i < 5; i++) step();
    check("bp_hold_result", rsp_result, 32'h13);
    check("bp_ready0", got0, 0);
    check("bp_ready1", got1, 0);
    rsp_ready = 1; step();
    check("bp_release_accept", got0, 1);
    check("bp_new_result", rsp_result, 32'hF000);
    set0(0, 0, 0, 0); step();
    set1(0, 0, 0, 0);

    // illegal op and slt
    set0(1, 3'b111, 32'h1234, 32'h5678); step();
    check("ill_flag", rsp_illegal, 1);
    check("ill_result", rsp_result, 0);
    set0(1, 3'b101, 3, 8); step();
    check("slt_lt", rsp_result, 1);
    set0(1, 3'b101, 8, 3); step();
    check("slt_ge", rsp_result, 0);
    check("slt_ge_illegal", rsp_illegal, 0);

    // reset while a result is held
    rsp_ready = 0; set0(1, 3'b000, 1, 1); step();
    check("pre_rst_valid", rsp_valid, 1);
    set1(1, 3'b000, 2, 2);
    reset = 1; step(); reset = 0;
    check("rst_ready0", got0, 0);
    check("rst_clear", {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal}, 0);
    step();
    check("post_rst_tie", got0, 1);
    set0(0, 0, 0, 0); rsp_ready = 1; step(); set1(0, 0, 0, 0); step();

    // randomized traffic
    p0 = 0; p1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1;
        set0(1, 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 4)) : $urandom,
             $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 4)) : $urandom);
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1;
        set1(1, 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 4)) : $urandom,
             $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 4)) : $urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 149) == 0);
      step();
      if (exp0) begin p0 = 0; req0_valid = 0; end
      if (exp1) begin p1 = 0; req1_valid = 0; end
    end
    reset = 0;
`ifdef ALU_SHARE_ARBITER_STATS_EN
    check("stat_grant0", stat_grant0, 64'(m_g0));
    check("stat_grant1", stat_grant1, 64'(m_g1));
    check("stat_conflict", stat_conflict, 64'(m_cf));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit integer ALU between two requesters.
  - Requester 0: main datapath.
  - Requester 1: address/branch-target helper.
- Round-robin arbitration, valid/ready handshake on the request side.
- One registered response slot, tagged with the requester id; one operation accepted per cycle.
- Sits between the decode/control logic and the ALU.

Parameters:
- DATA_W, 32, operand and result width.
- RESET_PRIO, 0, requester that wins the first tie after reset (0 or 1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  3  ALU control code.
- req0_a  input  DATA_W  operand A.
- req0_b  input  DATA_W  operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  output  1  response slot holds a result.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  requester that issued the held result.
- rsp_result  output  DATA_W  ALU result.
- rsp_zero  output  1  rsp_result == 0.
- rsp_illegal  output  1  held op was not a legal code.

Behaviour:
- Op codes:
  - 000 add, wraps mod 2^DATA_W.
  - 001 sub, wraps mod 2^DATA_W.
  - 010 and.
  - 011 or.
  - 101 slt: unsigned compare, result 1 if a<b else 0.
  - Any other code is illegal: result 0, rsp_illegal=1, rsp_zero=1.
- Slot-free condition:
  - slot_free = !rsp_valid || rsp_ready.
- Arbitration (combinational, every cycle):
  - One valid request: that requester wins.
  - Both valid: the requester not granted last wins.
  - last_grant resets so that RESET_PRIO wins the first tie.
- Grant:
  - reqN_ready = slot_free && (requester N is the winner).
  - At most one ready is high per cycle.
  - ready never asserts for a requester whose valid is low.
- Accept and latency:
  - Accept happens on reqN_valid && reqN_ready.
  - Next edge loads rsp_result, rsp_zero, rsp_illegal, rsp_id=N and sets rsp_valid=1. Latency is 1 cycle.
  - last_grant is updated to N.
- Response hold:
  - While rsp_valid && !rsp_ready, all rsp_* outputs stay stable.
  - No new accept happens while held.
- Throughput:
  - rsp_ready=1 with a pending request gives back-to-back accepts: one result per cycle.
- Drain:
  - rsp_valid && rsp_ready with no accept in the same cycle: rsp_valid clears next edge.
- Requester rules:
  - Requesters hold op/a/b stable and keep valid high until ready is seen.
  - The arbiter never drops a valid request. It is granted within 2 free slots (round-robin fairness).
- State machine:
  - EMPTY (rsp_valid=0) -> FULL on accept.
  - FULL -> FULL on rsp_ready && accept.
  - FULL -> EMPTY on rsp_ready && !accept.
  - FULL stays FULL on !rsp_ready.
- Reset:
  - Synchronous, takes priority over all other events.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_illegal=0, last_grant=!RESET_PRIO.
  - req0_ready and req1_ready are 0 during the reset cycle.
  - A held result is discarded.
  - A request presented during reset is not accepted; it is re-arbitrated after reset deasserts.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_STATS_EN.
- With the macro defined, the block adds:
  - output ports stat_grant0 and stat_grant1 (16 bits each): saturating counts of accepts per requester, saturating at 16'hFFFF.
  - output port stat_conflict (16 bits): saturating count of cycles where both valids were high and a slot was free.
  - All three counters reset to 0.
- Without the macro: the ports and counters do not exist. Arbitration and response behaviour are identical in both builds.

Test Plan:
- Single add: reset, then req0 op=000 a=5 b=7 with rsp_ready=1 -> req0_ready=1 the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
- Sub to zero and wrap:
  - req1 op=001 a=9 b=9 -> rsp_result=0, rsp_zero=1, rsp_id=1.
  - then op=000 a=32'hFFFFFFFF b=1 -> rsp_result=0, rsp_zero=1.
- Round-robin contention, both valid continuously, rsp_ready=1, RESET_PRIO=0:
  - grant order 0,1,0,1 over four cycles.
  - rsp_id sequence 0,1,0,1 with one result per cycle.
- Backpressure:
  - rsp_ready=0 after the first accept -> rsp_* held stable for 5 cycles, both ready=0.
  - raise rsp_ready -> next accept in the same cycle, new result the following cycle.
- Illegal op and slt:
  - op=111 -> rsp_illegal=1, rsp_result=0.
  - op=101 a=3 b=8 -> result 1.
  - op=101 a=8 b=3 -> result 0.
- Reset mid-operation:
  - assert reset while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0 and all rsp_* are 0.
  - pending req0 is accepted only after reset deasserts.
  - the first tie after reset goes to requester 0.
